// File: rtl/conv3x3_stream_if.sv
// Pixel stream bundle for conv3x3_stream: grey pixels in, convolved magnitudes and coordinates out.
interface conv3x3_stream_if #(
  parameter int DW = 12,
  parameter int XW = 11
);
  logic [DW-1:0] iDATA;
  logic          iDVAL;
  logic          iSOF;
  logic [DW-1:0] oDATA;
  logic          oDVAL;
  logic [XW-1:0] oX;
  logic [XW-1:0] oY;

  modport master (output iDATA, iDVAL, iSOF, input oDATA, oDVAL, oX, oY);
  modport slave  (input iDATA, iDVAL, iSOF, output oDATA, oDVAL, oX, oY);
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution (pass / Sobel Gx / Sobel Gy / user kernel) with two line buffers and a 4-stage pipeline.
// Optional build macro CONV_THRESH_EN adds iTHRESH and binarises the output against it.
module conv3x3_stream #(
  parameter int DW     = 12,
  parameter int LINE_W = 1280,
  parameter int XW     = 11
)(
  input  logic        iCLK,
  input  logic        iRST,
  conv3x3_stream_if.slave pix,
  input  logic [1:0]  iMODE,
  input  logic [35:0] iCOEF,
  input  logic [2:0]  iSHIFT
`ifdef CONV_THRESH_EN
  , input logic [DW-1:0] iTHRESH
`endif
);
  localparam int AW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int PW = DW + 5;
  localparam int SW = DW + 9;

  logic          accept;
  logic          sofAcc;
  logic [XW-1:0] x_q, y_q, pixX, pixY, x_d, y_d;
  logic [AW-1:0] addr;
  logic [1:0]    modeEff;
  logic [35:0]   coefEff;
  logic [2:0]    shiftEff;

  logic [1:0]    mode_q;
  logic [35:0]   coef_q;
  logic [2:0]    shift_q;

  logic [DW-1:0] lb1_q [LINE_W];
  logic [DW-1:0] lb2_q [LINE_W];
  logic [DW-1:0] win_q [9];

  logic          s1Val_q, s1Border_q;
  logic [XW-1:0] s1X_q, s1Y_q;
  logic [1:0]    s1Mode_q;
  logic [35:0]   s1Coef_q;
  logic [2:0]    s1Shift_q;

  logic signed [3:0]    k [9];
  logic signed [PW-1:0] prod_d [9];
  logic signed [PW-1:0] prod_q [9];
  logic          s2Val_q, s2Border_q;
  logic [XW-1:0] s2X_q, s2Y_q;
  logic [2:0]    s2Shift_q;

  logic signed [SW-1:0] sum_d, sum_q;
  logic          s3Val_q, s3Border_q;
  logic [XW-1:0] s3X_q, s3Y_q;
  logic [2:0]    s3Shift_q;

  logic [SW-1:0] mag, shifted;
  logic [DW-1:0] clamped, result;

  logic [DW-1:0] oData_q;
  logic          oDval_q;
  logic [XW-1:0] oX_q, oY_q;

`ifdef CONV_THRESH_EN
  logic [DW-1:0] thr_q, thrEff, s1Thr_q, s2Thr_q, s3Thr_q;
`endif

  assign accept = pix.iDVAL;
  assign sofAcc = pix.iDVAL & pix.iSOF;
  assign addr   = pixX[AW-1:0];

  // An accepted SOF forces the pixel to (0,0) and its own kernel settings take effect immediately
  always_comb begin
    pixX     = pix.iSOF ? '0 : x_q;
    pixY     = pix.iSOF ? '0 : y_q;
    modeEff  = sofAcc ? iMODE  : mode_q;
    coefEff  = sofAcc ? iCOEF  : coef_q;
    shiftEff = sofAcc ? iSHIFT : shift_q;
`ifdef CONV_THRESH_EN
    thrEff   = sofAcc ? iTHRESH : thr_q;
`endif
    if (pixX == XW'(LINE_W - 1)) begin
      x_d = '0;
      y_d = pixY + XW'(1);
    end else begin
      x_d = pixX + XW'(1);
      y_d = pixY;
    end
  end

  always_ff @(posedge iCLK) begin
    if (accept) begin
      lb1_q[addr] <= pix.iDATA;
      lb2_q[addr] <= lb1_q[addr];
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      x_q        <= '0;
      y_q        <= '0;
      mode_q     <= '0;
      coef_q     <= '0;
      shift_q    <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      s1Val_q    <= 1'b0;
      s1Border_q <= 1'b0;
      s1X_q      <= '0;
      s1Y_q      <= '0;
      s1Mode_q   <= '0;
      s1Coef_q   <= '0;
      s1Shift_q  <= '0;
`ifdef CONV_THRESH_EN
      thr_q      <= '0;
      s1Thr_q    <= '0;
`endif
    end else begin
      s1Val_q <= accept;
      if (accept) begin
        x_q <= x_d;
        y_q <= y_d;
        if (pix.iSOF) begin
          mode_q  <= iMODE;
          coef_q  <= iCOEF;
          shift_q <= iSHIFT;
`ifdef CONV_THRESH_EN
          thr_q   <= iTHRESH;
`endif
        end
        for (int r = 0; r < 3; r++) begin
          win_q[r*3]   <= win_q[r*3+1];
          win_q[r*3+1] <= win_q[r*3+2];
        end
        win_q[2]   <= lb2_q[addr];
        win_q[5]   <= lb1_q[addr];
        win_q[8]   <= pix.iDATA;
        s1Border_q <= (pixX < XW'(2)) || (pixY < XW'(2));
        s1X_q      <= pixX;
        s1Y_q      <= pixY;
        s1Mode_q   <= modeEff;
        s1Coef_q   <= coefEff;
        s1Shift_q  <= (modeEff == 2'd0) ? 3'd0 : shiftEff;
`ifdef CONV_THRESH_EN
        s1Thr_q    <= thrEff;
`endif
      end
    end
  end

  // Pass-through is a unit kernel on the centre tap, so every mode shares the multiply/sum path
  always_comb begin
    for (int i = 0; i < 9; i++) k[i] = '0;
    case (s1Mode_q)
      2'd0: k[4] = 4'sd1;
      2'd1: begin
        k[0] = -4'sd1; k[2] = 4'sd1;
        k[3] = -4'sd2; k[5] = 4'sd2;
        k[6] = -4'sd1; k[8] = 4'sd1;
      end
      2'd2: begin
        k[0] = -4'sd1; k[1] = -4'sd2; k[2] = -4'sd1;
        k[6] = 4'sd1;  k[7] = 4'sd2;  k[8] = 4'sd1;
      end
      default: for (int i = 0; i < 9; i++) k[i] = s1Coef_q[4*i +: 4];
    endcase
    for (int i = 0; i < 9; i++)
      prod_d[i] = PW'(signed'({1'b0, win_q[i]})) * PW'(k[i]);
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) sum_d = sum_d + SW'(prod_q[i]);
  end

  // The sum is wide enough that negating the most negative value never overflows
  always_comb begin
    mag     = sum_q[SW-1] ? -sum_q : sum_q;
    shifted = mag >> s3Shift_q;
    clamped = (|shifted[SW-1:DW]) ? '1 : shifted[DW-1:0];
`ifdef CONV_THRESH_EN
    result  = (clamped >= s3Thr_q) ? '1 : '0;
`else
    result  = clamped;
`endif
    if (s3Border_q) result = '0;
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
      s2Val_q    <= 1'b0;
      s2Border_q <= 1'b0;
      s2X_q      <= '0;
      s2Y_q      <= '0;
      s2Shift_q  <= '0;
      sum_q      <= '0;
      s3Val_q    <= 1'b0;
      s3Border_q <= 1'b0;
      s3X_q      <= '0;
      s3Y_q      <= '0;
      s3Shift_q  <= '0;
      oData_q    <= '0;
      oDval_q    <= 1'b0;
      oX_q       <= '0;
      oY_q       <= '0;
`ifdef CONV_THRESH_EN
      s2Thr_q    <= '0;
      s3Thr_q    <= '0;
`endif
    end else begin
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
      s2Val_q    <= s1Val_q;
      s2Border_q <= s1Border_q;
      s2X_q      <= s1X_q;
      s2Y_q      <= s1Y_q;
      s2Shift_q  <= s1Shift_q;
      sum_q      <= sum_d;
      s3Val_q    <= s2Val_q;
      s3Border_q <= s2Border_q;
      s3X_q      <= s2X_q;
      s3Y_q      <= s2Y_q;
      s3Shift_q  <= s2Shift_q;
`ifdef CONV_THRESH_EN
      s2Thr_q    <= s1Thr_q;
      s3Thr_q    <= s2Thr_q;
`endif
      oDval_q    <= s3Val_q;
      if (s3Val_q) begin
        oData_q <= result;
        oX_q    <= s3X_q;
        oY_q    <= s3Y_q;
      end
    end
  end

  assign pix.oDATA = oData_q;
  assign pix.oDVAL = oDval_q;
  assign pix.oX    = oX_q;
  assign pix.oY    = oY_q;
endmodule

// File: tb/tb_conv3x3_stream.sv
// Scoreboard bench for conv3x3_stream: randomised frames checked against an image-based reference model.
module tb_conv3x3_stream;
  localparam int DW     = 12;
  localparam int LINE_W = 8;
  localparam int XW     = 4;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [1:0]  iMODE;
  logic [35:0] iCOEF;
  logic [2:0]  iSHIFT;
`ifdef CONV_THRESH_EN
  logic [DW-1:0] iTHRESH;
`endif

  conv3x3_stream_if #(.DW(DW), .XW(XW)) pix();

  conv3x3_stream #(.DW(DW), .LINE_W(LINE_W), .XW(XW)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .pix    (pix),
    .iMODE  (iMODE),
    .iCOEF  (iCOEF),
    .iSHIFT (iSHIFT)
`ifdef CONV_THRESH_EN
    , .iTHRESH (iTHRESH)
`endif
  );

  always #5 iCLK = ~iCLK;

  int checkCount = 0;
  int passCount  = 0;
  int pulseCount = 0;
  int expQ[$];
  int frameImg[16][8];
  int img[16][8];
  int mX, mY, shMode, shShift, shThr;
  logic [35:0] shCoef;
  int cfgMode, cfgShift, cfgThr;
  logic [35:0] cfgCoef;
  bit scrambleCfg;
  int monE;
  int p0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Kernel taps straight from the mode definitions, row-major r=0 top, c=0 left
  function automatic int kernelTap(input int mode, input logic [35:0] coef, input int r, input int c);
    int gx[9];
    int gy[9];
    logic signed [3:0] nib;
    gx  = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    gy  = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    nib = coef[(r*3+c)*4 +: 4];
    case (mode)
      1:       return gx[r*3+c];
      2:       return gy[r*3+c];
      default: return int'(nib);
    endcase
  endfunction

  function automatic void modelReset();
    mX = 0; mY = 0;
    shMode = 0; shCoef = '0; shShift = 0; shThr = 0;
  endfunction

  function automatic void modelAccept(input int d, input bit sof);
    int px, py, v, s;
    if (sof) begin
      mX = 0; mY = 0;
      shMode = cfgMode; shCoef = cfgCoef; shShift = cfgShift; shThr = cfgThr;
    end
    px = mX;
    py = mY;
    img[py][px] = d;
    if (px < 2 || py < 2) v = 0;
    else begin
      if (shMode == 0) v = img[py-1][px-1];
      else begin
        s = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            s += kernelTap(shMode, shCoef, r, c) * img[py-2+r][px-2+c];
        if (s < 0) s = -s;
        v = s >> shShift;
        if (v > 4095) v = 4095;
      end
`ifdef CONV_THRESH_EN
      v = (v >= shThr) ? 4095 : 0;
`endif
    end
    expQ.push_back(v | (px << 12) | (py << 16));
    if (px == LINE_W - 1) begin
      mX = 0;
      mY = (py + 1) % 16;
    end else mX = px + 1;
  endfunction

  task automatic driveCfg(input bit rnd);
    if (rnd) begin
      iMODE  = 2'($urandom);
      iCOEF  = {4'($urandom), 32'($urandom)};
      iSHIFT = 3'($urandom);
`ifdef CONV_THRESH_EN
      iTHRESH = 12'($urandom);
`endif
    end else begin
      iMODE  = 2'(cfgMode);
      iCOEF  = cfgCoef;
      iSHIFT = 3'(cfgShift);
`ifdef CONV_THRESH_EN
      iTHRESH = 12'(cfgThr);
`endif
    end
  endtask

  task automatic applyStimulus(input int d, input bit sof, input int bubbles);
    for (int b = 0; b < bubbles; b++) begin
      pix.iDVAL = 1'b0;
      pix.iDATA = 12'($urandom);
      pix.iSOF  = 1'($urandom);
      driveCfg(scrambleCfg);
      @(posedge iCLK); #1;
    end
    pix.iDVAL = 1'b1;
    pix.iDATA = 12'(d);
    pix.iSOF  = sof;
    driveCfg(scrambleCfg && !sof);
    modelAccept(d, sof);
    @(posedge iCLK); #1;
    pix.iDVAL = 1'b0;
    pix.iSOF  = 1'b0;
  endtask

  task automatic sendFrame(input int rows, input int lastLen, input bit withSof, input int bubMin, input int bubMax);
    for (int y = 0; y < rows; y++)
      for (int x = 0; x < ((y == rows - 1) ? lastLen : LINE_W); x++)
        applyStimulus(frameImg[y][x], withSof && x == 0 && y == 0, int'($urandom_range(bubMax, bubMin)));
  endtask

  task automatic drain();
    repeat (8) @(posedge iCLK);
    #1;
  endtask

  task automatic fillTwoTone();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) frameImg[y][x] = (x < 4) ? 0 : 100;
  endtask

  task automatic fillRandom(input int maxVal);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) frameImg[y][x] = int'($urandom_range(maxVal, 0));
  endtask

  // Monitor: every output pulse consumes the oldest expected response
  always @(negedge iCLK) begin
    if (pix.oDVAL === 1'b1) begin
      pulseCount++;
      if (expQ.size() == 0) checkOutput("unexpected_pulse", 1, 0);
      else begin
        monE = expQ.pop_front();
        checkOutput("oDATA", int'(pix.oDATA), monE & 'hFFF);
        checkOutput("oX", int'(pix.oX), (monE >> 12) & 'hF);
        checkOutput("oY", int'(pix.oY), (monE >> 16) & 'hF);
      end
    end
  end

  initial begin
    iRST = 1'b0;
    pix.iDVAL = 1'b0; pix.iDATA = '0; pix.iSOF = 1'b0;
    cfgMode = 0; cfgShift = 0; cfgThr = 200; cfgCoef = '0;
    scrambleCfg = 1'b0;
    driveCfg(1'b0);
    modelReset();

    for (int i = 0; i < 6; i++) begin
      @(posedge iCLK); #1;
      pix.iDVAL = ~pix.iDVAL;
      pix.iDATA = 12'($urandom);
      pix.iSOF  = 1'b1;
      @(negedge iCLK);
      checkOutput("rst_oDVAL", int'(pix.oDVAL), 0);
      checkOutput("rst_oDATA", int'(pix.oDATA), 0);
    end
    checkOutput("rst_oX", int'(pix.oX), 0);
    checkOutput("rst_oY", int'(pix.oY), 0);
    @(posedge iCLK); #1;
    pix.iDVAL = 1'b0; pix.iSOF = 1'b0;
    iRST = 1'b1;
    @(posedge iCLK); #1;

    $display("[TB] latency");
    applyStimulus(123, 1'b0, 0);
    @(posedge iCLK); #1;
    @(posedge iCLK); #1;
    checkOutput("latency_early", int'(pix.oDVAL), 0);
    @(posedge iCLK); #1;
    checkOutput("latency_exact", int'(pix.oDVAL), 1);
    drain();

    $display("[TB] Sobel Gx two-tone");
    fillTwoTone();
    cfgMode = 1; cfgShift = 0;
    sendFrame(4, 8, 1'b1, 0, 0);
    drain();

    $display("[TB] Sobel Gy horizontal edge");
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) frameImg[y][x] = (y < 2) ? 100 : 0;
    cfgMode = 2; cfgShift = 0;
    sendFrame(4, 8, 1'b1, 0, 0);
    drain();

    $display("[TB] user kernel saturation and shift");
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) frameImg[y][x] = 4095;
    cfgMode = 3; cfgCoef = 36'h777777777; cfgShift = 0;
    sendFrame(4, 8, 1'b1, 0, 0);
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 8; x++) frameImg[y][x] = 10;
    cfgShift = 2;
    sendFrame(4, 8, 1'b1, 0, 0);
    drain();

    $display("[TB] bubbles and mid-frame config changes");
    fillTwoTone();
    cfgMode = 1; cfgShift = 0;
    scrambleCfg = 1'b1;
    p0 = pulseCount;
    sendFrame(4, 8, 1'b1, 2, 2);
    drain();
    checkOutput("pulse_count", pulseCount - p0, 32);

    $display("[TB] random frames");
    for (int f = 0; f < 6; f++) begin
      cfgMode  = int'($urandom_range(3, 0));
      cfgCoef  = {4'($urandom), 32'($urandom)};
      cfgShift = int'($urandom_range(7, 0));
      cfgThr   = int'($urandom_range(4095, 0));
      fillRandom((f % 2) ? 4095 : 63);
      sendFrame(int'($urandom_range(5, 3)), int'($urandom_range(8, 1)), 1'b1, 0, 2);
    end
    drain();

    $display("[TB] reset mid-frame");
    cfgMode = 3; cfgCoef = {4'($urandom), 32'($urandom)}; cfgShift = 1;
    fillRandom(4095);
    sendFrame(2, 5, 1'b1, 0, 1);
    iRST = 1'b0;
    expQ.delete();
    modelReset();
    @(negedge iCLK);
    checkOutput("midrst_oDVAL", int'(pix.oDVAL), 0);
    @(posedge iCLK); #1;
    iRST = 1'b1;
    fillRandom(4095);
    sendFrame(3, 8, 1'b0, 0, 1);
    drain();

    checkOutput("queue_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
